// File: rtl/core_ctrl_pkg.sv
// core_run_ctrl shared types: FSM state encoding and default counter width.
// Build option: define STEP_DEBOUNCE_EN to debounce step_btn.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } run_state_e;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Control/status bundle between core_run_ctrl (master) and the core/debug side.
// Build option: STEP_DEBOUNCE_EN does not change this bundle.
interface core_run_ctrl_if #(
  parameter int unsigned CNT_W = core_ctrl_pkg::CNT_W_DEF
) ();

  logic             run_sw;
  logic             step_btn;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             core_ce;
  logic             halted;
  logic             bp_hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run_sw, step_btn, bp_en, bp_addr, pc,
    output core_ce, halted, bp_hit, state, instr_count
  );

  modport slave (
    output run_sw, step_btn, bp_en, bp_addr, pc,
    input  core_ce, halted, bp_hit, state, instr_count
  );

endinterface

// File: rtl/btn_sync_edge.sv
// 2-flop synchroniser, optional debounce (STEP_DEBOUNCE_EN) and registered rise.
// The rise pulse is one clk wide and lags the synced level by one cycle.
module btn_sync_edge #(
  parameter int unsigned DB_CYCLES = 1,
  parameter bit          USE_DB    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q;
  logic prev_q, rise_q;
  logic lvl;

  if (USE_DB && DB_CYCLES == 0) begin : g_bad_db
    $error("btn_sync_edge: DB_CYCLES must be >= 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  if (USE_DB) begin : g_db
    logic        db_q;
    logic [31:0] cnt_q;

    // Level only moves after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_q  <= 1'b0;
        cnt_q <= '0;
      end else if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 32'(DB_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign lvl = db_q;
  end else begin : g_nodb
    assign lvl = s2_q;
  end
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      rise_q <= lvl & ~prev_q;
    end
  end

  assign level_o = lvl;
  assign rise_o  = rise_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/breakpoint sequencer producing the core's one-cycle clock enable.
// Build option: STEP_DEBOUNCE_EN adds a DB_CYCLES debounce on step_btn.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input logic            clk,
  input logic            reset,
  core_run_ctrl_if.master bus
);

  localparam logic [1:0]  ST_HALT  = S_HALT;
  localparam logic [1:0]  ST_RUN   = S_RUN;
  localparam logic [1:0]  ST_STEP  = S_STEP;
  localparam logic [1:0]  ST_BREAK = S_BREAK;
  localparam logic [31:0] TICK_MAX = 32'(TICK_DIV - 1);

  if (TICK_DIV == 0) begin : g_bad_tick
    $error("core_run_ctrl: TICK_DIV must be >= 1");
  end

  logic [31:0]      tick_q, tick_d;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_s, step_rise;
  logic             bp_match;
  logic             step_lvl_unused;
  logic             run_rise_unused;

  btn_sync_edge #(
    .DB_CYCLES (DB_CYCLES),
    .USE_DB    (1'b1)
  ) u_step_sync (
    .clk     (clk),
    .rst     (reset),
    .d_i     (bus.step_btn),
    .level_o (step_lvl_unused),
    .rise_o  (step_rise)
  );

  btn_sync_edge #(
    .DB_CYCLES (DB_CYCLES),
    .USE_DB    (1'b0)
  ) u_run_sync (
    .clk     (clk),
    .rst     (reset),
    .d_i     (bus.run_sw),
    .level_o (run_s),
    .rise_o  (run_rise_unused)
  );

  assign tick     = (tick_q == TICK_MAX);
  assign tick_d   = tick ? 32'd0 : tick_q + 32'd1;
  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);
  assign cnt_d    = cnt_q + CNT_W'(ce_q);

  // STEP ignores both run_s and the breakpoint so a break can be stepped past.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (run_s)          state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (!run_s)         state_d = ST_HALT;
        else if (tick) begin
          if (bp_match)     state_d = ST_BREAK;
          else              ce_d    = 1'b1;
        end
      end
      ST_STEP: begin
        if (tick) begin
          ce_d    = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_BREAK: begin
        if (step_rise)      state_d = ST_STEP;
        else if (!run_s)    state_d = ST_HALT;
      end
      default:              state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      state_q <= ST_HALT;
      ce_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.core_ce     = ce_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign bus.bp_hit      = (state_q == ST_BREAK);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: expected pulses queued by stimulus,
// popped and compared by a monitor on every observed core_ce pulse.
module tb_core_run_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  core_run_ctrl_if #(.CNT_W(16)) bus ();
  core_run_ctrl_if #(.CNT_W(16)) wbus ();

  core_run_ctrl #(
    .TICK_DIV (TD),
    .CNT_W    (16),
    .DB_CYCLES(DB)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  core_run_ctrl #(
    .TICK_DIV (1),
    .CNT_W    (16),
    .DB_CYCLES(DB)
  ) u_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (wbus.master)
  );

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_on = 1'b0;
  bit          gap_chk = 1'b0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_pulse = -1;
  logic [31:0] pc_m;
  bit          pc_clr = 1'b1;

  assign bus.pc = pc_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] pc, input int cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = 16'(cnt);
    sb_q.push_back(e);
  endtask

  // Core model: PC advances by 4 on every enabled edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pc_clr)           pc_m <= 32'h0;
    else if (bus.core_ce) pc_m <= pc_m + 32'd4;
  end

  always @(negedge clk) begin
    if (!gap_chk) last_pulse = -1;
    if (bus.core_ce === 1'b1) begin
      if (gap_chk) begin
        if (last_pulse >= 0) chk("pulse_gap", 32'(cyc - last_pulse), TD);
        last_pulse = cyc;
      end
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: pc 0x%0h with nothing expected",
                   bus.pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("pulse_pc", bus.pc, e.pc);
          chk("pulse_cnt", 32'(bus.instr_count), 32'(e.cnt));
        end
      end
      pulses++;
    end
  end

  initial begin
    int p0;
    int base;
    int bad;
    int t;

    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;
    wbus.run_sw   = 1'b0;
    wbus.step_btn = 1'b0;
    wbus.bp_en    = 1'b0;
    wbus.bp_addr  = 32'h0;
    wbus.pc       = 32'h0;

    ncyc(3);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_ce", 32'(bus.core_ce), 0);
    chk("rst_halted", 32'(bus.halted), 1);
    chk("rst_bp_hit", 32'(bus.bp_hit), 0);
    chk("rst_count", 32'(bus.instr_count), 0);
    reset = 1'b0;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.state !== 2'd0 || bus.core_ce !== 1'b0) bad++;
    end
    chk("halt_idle", 32'(bad), 0);
    chk("halt_count", 32'(bus.instr_count), 0);
    chk("halt_halted", 32'(bus.halted), 1);

    // Free run without breakpoint
    pc_clr = 1'b0;
    gap_chk = 1'b1;
    p0 = pulses;
    bus.run_sw = 1'b1;
    ncyc(40);
    chk("run_rate", 32'((pulses - p0 >= 9) && (pulses - p0 <= 11)), 1);
    chk("run_count", 32'(bus.instr_count), 32'(pulses));
    chk("run_state", 32'(bus.state), 1);
    chk("run_halted", 32'(bus.halted), 0);
    bus.run_sw = 1'b0;
    gap_chk = 1'b0;
    ncyc(6);
    chk("stop_state", 32'(bus.state), 0);
    p0 = pulses;
    ncyc(20);
    chk("stop_no_pulse", 32'(pulses - p0), 0);

    // Single step from HALT
    pc_clr = 1'b1;
    ncyc(2);
    pc_clr = 1'b0;
    sb_on = 1'b1;
    p0 = pulses;
    push_exp(32'h0, pulses);
    bus.step_btn = 1'b1;
    fork
      begin ncyc(5); bus.step_btn = 1'b0; end
    join_none
    ncyc(LAT);
    chk("step_early", 32'(bus.state), 0);
    ncyc(1);
    chk("step_lat", 32'(bus.state), 2);
    chk("step_halted", 32'(bus.halted), 0);
    ncyc(20);
    chk("step_back_halt", 32'(bus.state), 0);
    chk("step_drain", 32'(sb_q.size()), 0);
    chk("step_one_pulse", 32'(pulses - p0), 1);

    // Run into breakpoint at 0x10
    pc_clr = 1'b1;
    ncyc(2);
    pc_clr = 1'b0;
    base = pulses;
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i), base + i);
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    bus.run_sw  = 1'b1;
    for (t = 0; t < 60 && bus.state !== 2'd3; t++) @(negedge clk);
    chk("bp_reach", 32'(bus.state), 3);
    chk("bp_hit", 32'(bus.bp_hit), 1);
    chk("bp_halted", 32'(bus.halted), 1);
    chk("bp_drain", 32'(sb_q.size()), 0);
    chk("bp_pc", pc_m, 32'h10);
    ncyc(12);
    chk("break_hold", 32'(bus.state), 3);
    chk("break_ce", 32'(bus.core_ce), 0);
    chk("break_count", 32'(bus.instr_count), 32'(base + 4));

    // Step past the breakpoint, then RUN resumes
    push_exp(32'h10, base + 4);
    push_exp(32'h14, base + 5);
    push_exp(32'h18, base + 6);
    bus.step_btn = 1'b1;
    fork
      begin ncyc(5); bus.step_btn = 1'b0; end
    join_none
    for (t = 0; t < 80 && sb_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    sb_on = 1'b0;
    chk("resume_drain", 32'(sb_q.size()), 0);
    chk("resume_state", 32'(bus.state), 1);
    chk("resume_bp_hit", 32'(bus.bp_hit), 0);
    bus.run_sw = 1'b0;
    bus.bp_en  = 1'b0;
    ncyc(6);
    chk("resume_stop", 32'(bus.state), 0);

`ifdef STEP_DEBOUNCE_EN
    p0 = pulses;
    bus.step_btn = 1'b1;
    ncyc(2);
    bus.step_btn = 1'b0;
    ncyc(15);
    chk("glitch_state", 32'(bus.state), 0);
    chk("glitch_no_pulse", 32'(pulses - p0), 0);
`endif

    // Reset in the middle of a pulse
    bus.run_sw = 1'b1;
    for (t = 0; t < 40 && bus.core_ce !== 1'b1; t++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_ce_seen", 32'(bus.core_ce), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ce", 32'(bus.core_ce), 0);
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_count", 32'(bus.instr_count), 0);
    bus.run_sw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ncyc(5);
    chk("post_rst_state", 32'(bus.state), 0);

    // Counter wrap on the TICK_DIV=1 instance
    wbus.run_sw = 1'b1;
    for (t = 0; t < 70000 && wbus.instr_count !== 16'hFFFF; t++)
      @(negedge clk);
    chk("wrap_ffff", 32'(wbus.instr_count), 32'hFFFF);
    chk("wrap_b2b_ce", 32'(wbus.core_ce), 1);
    @(negedge clk);
    chk("wrap_zero", 32'(wbus.instr_count), 0);
    wbus.run_sw = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/step/breakpoint controller that sequences the RV32 core by generating its single-cycle clock-enable `core_ce`.
- Replaces the free-running slow clock as the core's advance signal; the core clocks on `clk` and gates its state flops with `core_ce`.
- Exposes halt/break status and a retired-pulse counter for the seven-segment/LED debug path.

Parameters:
- TICK_DIV, 50_000_000, clk cycles between permitted `core_ce` pulses in RUN/STEP; legal range 1 to 2^32-1; 1 = every cycle.
- CNT_W, 16, width of `instr_count`.
- DB_CYCLES, 1_000_000, stable cycles required on `step_btn` (only with STEP_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run_sw  in  1  asynchronous level; 1 = run requested
- step_btn  in  1  asynchronous push-button; a rising edge = one step
- bp_en  in  1  breakpoint enable; synchronous to clk
- bp_addr  in  32  breakpoint PC; synchronous to clk
- pc  in  32  current core PC; updated on the clk edge where `core_ce` = 1
- core_ce  out  1  one-clk enable pulse to the core
- halted  out  1  1 in HALT or BREAK
- bp_hit  out  1  1 in BREAK
- state  out  2  HALT=0, RUN=1, STEP=2, BREAK=3
- instr_count  out  CNT_W  number of `core_ce` pulses issued; wraps

Behaviour:
- Reset (async): state=HALT, core_ce=0, halted=1, bp_hit=0, instr_count=0, tick counter=0, synchronisers cleared.
- Reset asserted mid-pulse drops `core_ce` immediately.
- Synchronisers:
  - `run_sw` and `step_btn` each pass through a 2-flop synchroniser.
  - `step_rise` = synced & ~previous synced, one clk wide.
  - A `step_btn` rise sampled at edge k gives state=STEP after edge k+3.
- Tick counter:
  - Free-running 0..TICK_DIV-1; `tick` = (count == TICK_DIV-1).
  - Wraps to 0; never stops, including in HALT.
- HALT:
  - run_s=1 -> RUN.
  - Else step_rise -> STEP.
  - run_s has priority over step_rise in the same cycle.
- RUN:
  - On tick: if bp_en && pc==bp_addr -> BREAK with no pulse.
  - Otherwise on tick, register core_ce=1 for exactly one cycle.
  - run_s=0 -> HALT; takes priority over tick in the same cycle.
- STEP:
  - On the next tick, issue one core_ce pulse and go to HALT.
  - The breakpoint is ignored in STEP, which is the mechanism for stepping past a breakpoint.
  - run_s changes are ignored until the step is done.
- BREAK:
  - core_ce=0.
  - step_rise -> STEP.
  - run_s=0 -> HALT.
  - If both occur in the same cycle, STEP wins.
- Continue after a break: step while run_sw=1 gives STEP -> HALT -> RUN on the next cycle.
- `core_ce` is registered (driven from a flop) and is never high two consecutive cycles unless TICK_DIV=1 in RUN.
- instr_count += 1 on every cycle core_ce=1; 2^CNT_W-1 wraps to 0.
- `halted` and `bp_hit` are decoded combinationally from the state register.

Optional Feature:
- Macro: STEP_DEBOUNCE_EN.
- When defined:
  - The synced `step_btn` must hold a new level for DB_CYCLES consecutive clk before the debounced level updates.
  - `step_rise` is taken from the debounced level.
  - Adds DB_CYCLES latency; glitches shorter than DB_CYCLES produce no step.
- When undefined: `step_rise` is taken directly from the synchroniser; DB_CYCLES is unused.

Decomposition:
- Package `core_ctrl_pkg`: state enum (HALT, RUN, STEP, BREAK; 2-bit) and the default CNT_W constant.
- Sub-module `btn_sync_edge`:
  - Contains the 2-flop synchroniser, the optional debounce counter and the rise detector.
  - Instantiated for `step_btn`.
  - Also used for `run_sw`, with only its level output consumed.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
- Reset released, run_sw=0 -> state=0, core_ce=0 for 50 cycles, instr_count=0, halted=1.
- run_sw=1, bp_en=0 -> one core_ce pulse every 4 clk; after 40 clk instr_count ~10 ±1; run_sw=0 -> HALT and no further pulses.
- HALT, single step_btn pulse of 5 clk -> state=STEP after 3 edges, exactly one core_ce pulse, back to HALT, instr_count+1.
- bp_en=1, bp_addr=0x10, model pc += 4 per pulse from 0 -> pulses at pc 0, 4, 8, 0xC; then BREAK, bp_hit=1, no pulse at 0x10.
- From BREAK with run_sw=1, step -> one pulse (pc 0x10 -> 0x14), then RUN resumes.
- Edge cases:
  - Preset instr_count 0xFFFF (force) plus one pulse -> wraps to 0x0000.
  - Reset asserted while core_ce=1 -> core_ce=0 before the next clk edge.
  - With STEP_DEBOUNCE_EN, a 2-clk step glitch -> no step.
